// File: rtl/key_debounce.sv
// Key/switch debouncer: 2-flop synchroniser, consecutive-stability counter and
// a 4-state qualification FSM producing a clean level plus rise/fall pulses.
module key_debounce #(
  parameter  int CNT_MAX = 1000000,
  localparam int CW      = $clog2(CNT_MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_rise,
  output logic key_fall,
  output logic busy
);

  // state     | meaning
  // IDLE_LOW  | level 0 accepted, waiting for a high sample
  // CHK_HIGH  | qualifying a candidate 0->1 transition
  // IDLE_HIGH | level 1 accepted, waiting for a low sample
  // CHK_LOW   | qualifying a candidate 1->0 transition
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sync1, sync2;
  logic          level_nxt, rise_nxt, fall_nxt;
  logic          cnt_done;

  assign cnt_done = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      state     <= IDLE_LOW;
      cnt       <= '0;
      key_level <= 1'b0;
      key_rise  <= 1'b0;
      key_fall  <= 1'b0;
    end else begin
      sync1     <= key_in;
      sync2     <= sync1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      key_level <= level_nxt;
      key_rise  <= rise_nxt;
      key_fall  <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_LOW:  if (sync2) state_nxt = CHK_HIGH;
      CHK_HIGH: begin
        if (!sync2)        state_nxt = IDLE_LOW;
        else if (cnt_done) state_nxt = IDLE_HIGH;
      end
      IDLE_HIGH: if (!sync2) state_nxt = CHK_LOW;
      CHK_LOW: begin
        if (sync2)         state_nxt = IDLE_HIGH;
        else if (cnt_done) state_nxt = IDLE_LOW;
      end
      default:   state_nxt = IDLE_LOW;
    endcase
  end

  // Counter only advances while the candidate value persists; any state change clears it.
  always_comb begin
    cnt_nxt   = '0;
    level_nxt = key_level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      CHK_HIGH: begin
        if (sync2) begin
          if (cnt_done) begin
            level_nxt = 1'b1;
            rise_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      CHK_LOW: begin
        if (!sync2) begin
          if (cnt_done) begin
            level_nxt = 1'b0;
            fall_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

  assign busy = (state == CHK_HIGH) || (state == CHK_LOW);

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions one raw mechanical key/switch input into a clean, glitch-free level plus single-cycle edge pulses.
- Sits directly upstream of the 1-bit D flip-flop stage: key_level or key_rise drives the flop's d input (or its enable logic).
- Combines a 2-flop synchroniser, a stability counter and a 4-state FSM, all on a single clock.

Parameters:
- CNT_MAX, 1000000, number of consecutive clk cycles the synchronised input must hold a new value before it is accepted (20 ms at 50 MHz); legal range >= 2.
- CW, $clog2(CNT_MAX), counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- key_in  input  1  raw asynchronous key level, active-high (1 = pressed).
- key_level  output  1  debounced key level, registered.
- key_rise  output  1  one-cycle pulse when key_level goes 0->1, registered.
- key_fall  output  1  one-cycle pulse when key_level goes 1->0, registered.
- busy  output  1  high while a candidate transition is being qualified (FSM in CHK_HIGH or CHK_LOW).

Behaviour:
- Reset:
  - When rst=1 at a clk edge, clear sync1, sync2, the counter and all outputs to 0, and move the FSM to IDLE_LOW.
  - Reset has priority over every other event, including one mid-qualification.
- Synchroniser: sync1<=key_in; sync2<=sync1. Only sync2 feeds the FSM.
- FSM states: IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW.
  - IDLE_LOW: if sync2=1, go to CHK_HIGH with cnt<=0; else stay with cnt held at 0.
  - CHK_HIGH:
    - sync2=0: return to IDLE_LOW, cnt<=0, no pulse (glitch rejected).
    - sync2=1 and cnt==CNT_MAX-1: go to IDLE_HIGH, key_level<=1, key_rise<=1, cnt<=0.
    - Otherwise: cnt<=cnt+1.
  - IDLE_HIGH: if sync2=0, go to CHK_LOW with cnt<=0.
  - CHK_LOW: mirror of CHK_HIGH. On sync2=1 return to IDLE_HIGH. On acceptance go to IDLE_LOW, key_level<=0, key_fall<=1.
- Pulses: key_rise and key_fall are high for exactly one cycle and are forced to 0 on every other cycle. They are never high simultaneously.
- Latency:
  - key_level changes on the (CNT_MAX+3)th rising edge after the first edge that samples the new key_in value, provided key_in holds steady.
  - Breakdown: 2 synchroniser edges, 1 IDLE->CHK edge, CNT_MAX counting edges.
  - The pulse asserts on the same edge as the key_level change.
- busy is decoded combinationally from the FSM state: 1 in CHK_HIGH/CHK_LOW, 0 otherwise.
- Counter:
  - Unsigned, CW bits wide.
  - Never exceeds CNT_MAX-1, so no wrap-around occurs.
  - Cleared on every state change.
- Any bounce that returns sync2 to the current key_level during CHK restarts qualification from zero. Debounce time is consecutive, not cumulative.
- key_in held high through reset: after rst falls, qualification starts from scratch. key_level rises CNT_MAX+3 edges after the first edge with rst=0.

Test Plan (CNT_MAX=4 override):
1. Reset: hold rst=1 for 3 cycles with key_in toggling -> key_level=0, key_rise=0, key_fall=0, busy=0 throughout.
2. Clean press: key_in 0->1 and held -> busy rises at edge 3; key_level=1 and key_rise=1 at edge 7; key_rise=0 at edge 8; key_level stays 1.
3. Bounce rejection: key_in pattern 1,1,1,0,1,1,1,1,1,1 (one value per cycle) -> no key_rise during the bounce; key_level rises exactly 7 edges after the final 0->1 sample, with a single key_rise pulse.
4. Release: from key_level=1, key_in 1->0 held -> key_fall=1 and key_level=0 at edge 7; exactly one key_fall pulse.
5. Short glitch: from IDLE_LOW, key_in=1 for 2 cycles then 0 -> busy pulses high then returns low; key_level, key_rise and key_fall stay 0.
6. Reset mid-operation: assert rst while in CHK_HIGH (cnt=2), deassert next cycle with key_in still 1 -> outputs 0 during reset; key_level rises 7 edges after the first post-reset edge.
